// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction-memory responder.
package imem_pkg;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} imem_state_t;

  localparam logic [31:0] IMEM_NOP = 32'h0000_0013;  // addi x0,x0,0

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        err;
  } imem_resp_t;

  function automatic logic pc_in_range(input logic [31:0] pc, input int addr_w);
    return (pc >> addr_w) == 32'd0;
  endfunction

endpackage

// File: rtl/imem_array.sv
// Instruction storage: one synchronous write port, two asynchronous read ports.
module imem_array #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [31:0]       wr_data,
  input  logic [ADDR_W-1:0] rd_addr0,
  output logic [31:0]       rd_data0,
  input  logic [ADDR_W-1:0] rd_addr1,
  output logic [31:0]       rd_data1
);

  logic [31:0] mem_q [2**ADDR_W];

  // Contents survive reset so a loaded program is kept across core resets.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  assign rd_data0 = mem_q[rd_addr0];
  assign rd_data1 = mem_q[rd_addr1];

endmodule

// File: rtl/imem_responder.sv
// Fetch-stage responder with programmable latency and flush.
// Define IMEM_PREFETCH_EN to add a one-entry pc+1 prefetch buffer.
module imem_responder
  import imem_pkg::*;
#(
  parameter int ADDR_W  = 10,
  parameter int LATENCY = 2
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              req_valid,
  input  logic [31:0]       req_pc,
  output logic              req_ready,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [31:0]       resp_pc,
  output logic [31:0]       resp_instr,
  output logic              resp_err,
  input  logic              flush,
  input  logic              load_en,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [31:0]       load_data
);

  imem_state_t state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  imem_resp_t  resp_q, resp_d;
  logic [31:0] rd_data0;
  logic        accept;
  logic        req_in_range;

`ifdef IMEM_PREFETCH_EN
  logic        pf_valid_q, pf_valid_d;
  logic [31:0] pf_tag_q, pf_tag_d;
  logic [31:0] pf_data_q, pf_data_d;
  logic [31:0] pf_addr;
  logic [31:0] rd_data1;
  logic        pf_hit;

  assign pf_addr = req_pc + 32'd1;
  assign pf_hit  = pf_valid_q && (req_pc == pf_tag_q);
`else
  logic [31:0] pf_rd_unused;
`endif

  imem_array #(.ADDR_W(ADDR_W)) u_array (
    .clk      (clk),
    .wr_en    (load_en),
    .wr_addr  (load_addr),
    .wr_data  (load_data),
    .rd_addr0 (req_pc[ADDR_W-1:0]),
    .rd_data0 (rd_data0),
`ifdef IMEM_PREFETCH_EN
    .rd_addr1 (pf_addr[ADDR_W-1:0]),
    .rd_data1 (rd_data1)
`else
    .rd_addr1 (req_pc[ADDR_W-1:0]),
    .rd_data1 (pf_rd_unused)
`endif
  );

  assign req_ready    = (state_q == IDLE) || ((state_q == RESP) && resp_ready);
  assign accept       = req_valid && req_ready && !flush;
  assign req_in_range = pc_in_range(req_pc, ADDR_W);

  assign resp_valid = (state_q == RESP);
  assign resp_pc    = resp_q.pc;
  assign resp_instr = resp_q.instr;
  assign resp_err   = resp_q.err;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    resp_d  = resp_q;
    case (state_q)
      IDLE: ;
      WAIT: begin
        if (cnt_q <= 4'd1) begin
          state_d = RESP;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: if (resp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // The word is captured at acceptance; later writes cannot disturb it.
    if (accept) begin
      resp_d.pc    = req_pc;
      resp_d.err   = !req_in_range;
      resp_d.instr = req_in_range ? rd_data0 : IMEM_NOP;
      if (LATENCY == 1) begin
        state_d = RESP;
        cnt_d   = 4'd0;
      end else begin
        state_d = WAIT;
        cnt_d   = 4'(LATENCY - 1);
      end
`ifdef IMEM_PREFETCH_EN
      if (pf_hit) begin
        state_d      = RESP;
        cnt_d        = 4'd0;
        resp_d.instr = pf_data_q;
      end
`endif
    end

    if (flush) begin
      state_d = IDLE;
      cnt_d   = 4'd0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      resp_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      resp_q  <= resp_d;
    end
  end

`ifdef IMEM_PREFETCH_EN
  always_comb begin
    pf_valid_d = pf_valid_q;
    pf_tag_d   = pf_tag_q;
    pf_data_d  = pf_data_q;
    if (accept) begin
      pf_tag_d   = pf_addr;
      pf_valid_d = pc_in_range(pf_addr, ADDR_W);
      pf_data_d  = rd_data1;
    end
    // A same-cycle write to pc+1 also kills the freshly captured (stale) word.
    if (load_en && (pf_tag_d == {{(32-ADDR_W){1'b0}}, load_addr})) begin
      pf_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pf_valid_q <= 1'b0;
      pf_tag_q   <= 32'd0;
      pf_data_q  <= 32'd0;
    end else begin
      pf_valid_q <= pf_valid_d;
      pf_tag_q   <= pf_tag_d;
      pf_data_q  <= pf_data_d;
    end
  end
`endif

endmodule
